// File: rtl/rf_arb_pkg.sv
// Shared widths, entry layout and FSM encoding for the register-file
// write-back arbiter.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// MDU result queue: DEPTH-entry FIFO with per-entry valid bits and a
// two-port destination-register match for decode hazard detection.
module rf_wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [REG_AW-1:0]         push_addr,
  input  logic [REG_DW-1:0]         push_wd,
  input  logic                      pop,
  output logic [REG_AW-1:0]         head_addr,
  output logic [REG_DW-1:0]         head_wd,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  input  logic [REG_AW-1:0]         q_addr1,
  input  logic [REG_AW-1:0]         q_addr2,
  output logic                      q_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t            mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: push_addr, data: push_wd};
  end

  assign head_addr = mem[rd_ptr].addr;
  assign head_wd   = mem[rd_ptr].data;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  always_comb begin
    q_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] &&
          (((q_addr1 != '0) && (mem[i].addr == q_addr1)) ||
           ((q_addr2 != '0) && (mem[i].addr == q_addr2))))
        q_hit = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority over
// queued MDU results, with a bounded-wait forced MDU grant.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_addr,
  input  logic [REG_DW-1:0] pipe_wd,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_addr,
  input  logic [REG_DW-1:0] mdu_wd,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [REG_DW-1:0] rf_wd,
  input  logic [REG_AW-1:0] q_addr1,
  input  logic [REG_AW-1:0] q_addr2,
  output logic              q_hit
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WW-1:0]     wait_cnt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     cnt_nxt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fifo_hit;
  logic [REG_AW-1:0] head_addr;
  logic [REG_DW-1:0] head_wd;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (mdu_addr),
    .push_wd   (mdu_wd),
    .pop       (pop),
    .head_addr (head_addr),
    .head_wd   (head_wd),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_hit     (fifo_hit)
  );

  // Writes to r0 are acknowledged but never enter the queue.
  assign mdu_ready  = !rst && !full;
  assign push       = mdu_valid && mdu_ready && (mdu_addr != '0);
  assign pop        = !rst && !empty && (!pipe_we || (state == ST_FORCE));
  assign pipe_stall = !rst && (state == ST_FORCE) && pipe_we;
  assign q_hit      = !rst && fifo_hit;

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = pipe_addr;
    rf_wd = pipe_wd;
    if (pop) begin
      rf_we = 1'b1;
      rf_a3 = head_addr;
      rf_wd = head_wd;
    end else if (!rst) begin
      rf_we = pipe_we && (pipe_addr != '0);
    end
  end

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)
      cnt_nxt = count + CW'(1);
    else if (pop && !push)
      cnt_nxt = count - CW'(1);

    state_nxt = state;
    case (state)
      ST_IDLE:  if (push) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (cnt_nxt == '0)
          state_nxt = ST_IDLE;
        else if (!pop && (wait_cnt == WAIT_LAST))
          state_nxt = ST_FORCE;
      end
      ST_FORCE: state_nxt = (cnt_nxt != '0) ? ST_DRAIN : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_wd;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_hit;

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wd    (pipe_wd),
    .pipe_stall (pipe_stall),
    .mdu_valid  (mdu_valid),
    .mdu_addr   (mdu_addr),
    .mdu_wd     (mdu_wd),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd),
    .q_addr1    (q_addr1),
    .q_addr2    (q_addr2),
    .q_hit      (q_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   unserved = 0;
  bit   force_m  = 1'b0;
  int   errs     = 0;
  int   checks   = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    unserved = 0;
    force_m  = 1'b0;
  endtask

  // Evaluate the current cycle against the model, then advance the model
  // to the state it should hold after the coming rising edge.
  task automatic model_check();
    int n     = mq.size();
    bit grant = (n != 0) && (!pipe_we || force_m);
    bit ready = (n < DEPTH);
    bit hit   = 1'b0;
    foreach (mq[i])
      if (((q_addr1 != 0) && (mq[i].a == q_addr1)) ||
          ((q_addr2 != 0) && (mq[i].a == q_addr2)))
        hit = 1'b1;
    check_eq("m_ready", mdu_ready, ready);
    check_eq("m_stall", pipe_stall, force_m && pipe_we);
    check_eq("m_we", rf_we, grant || (pipe_we && (pipe_addr != 0)));
    check_eq("m_a3", rf_a3, grant ? mq[0].a : pipe_addr);
    check_eq("m_wd", rf_wd, grant ? mq[0].d : pipe_wd);
    check_eq("m_qhit", q_hit, hit);
    if (grant) void'(mq.pop_front());
    if (mdu_valid && ready && (mdu_addr != 0)) mq.push_back('{mdu_addr, mdu_wd});
    if ((n != 0) && !grant) unserved++;
    else unserved = 0;
    force_m = (unserved == MAX_WAIT);
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we   = 1'b0;
    pipe_addr = '0;
    pipe_wd   = '0;
    mdu_valid = 1'b0;
    mdu_addr  = '0;
    mdu_wd    = '0;
    q_addr1   = '0;
    q_addr2   = '0;
  endtask

  task automatic set_mdu(input logic [4:0] a, input logic [31:0] d);
    mdu_valid = 1'b1;
    mdu_addr  = a;
    mdu_wd    = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    #2;
    pipe_we   = 1'b1;
    pipe_addr = 5'd4;
    set_mdu(5'd3, 32'h3);
    #1;
    check_eq("rst_we", rf_we, 1'b0);
    check_eq("rst_ready", mdu_ready, 1'b0);
    check_eq("rst_stall", pipe_stall, 1'b0);
    check_eq("rst_qhit", q_hit, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    model_reset();

    // Pass-through with an empty queue
    pipe_we = 1'b1; pipe_addr = 5'd8; pipe_wd = 32'h1234;
    at_neg();
    check_eq("pt_we", rf_we, 1'b1);
    check_eq("pt_a3", rf_a3, 5'd8);
    check_eq("pt_wd", rf_wd, 32'h1234);
    check_eq("pt_stall", pipe_stall, 1'b0);
    to_pos();

    // Idle-slot drain
    idle_inputs();
    set_mdu(5'd9, 32'hDEAD);
    at_neg(); to_pos();
    idle_inputs();
    at_neg();
    check_eq("drain_we", rf_we, 1'b1);
    check_eq("drain_a3", rf_a3, 5'd9);
    check_eq("drain_wd", rf_wd, 32'hDEAD);
    to_pos();
    at_neg();
    check_eq("drain_ready", mdu_ready, 1'b1);
    check_eq("drain_we_after", rf_we, 1'b0);
    to_pos();

    // Starvation: pipeline wins four cycles, then one forced MDU slot
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_wd = 32'h3333;
    set_mdu(5'd5, 32'h55);
    at_neg(); to_pos();
    mdu_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      at_neg();
      check_eq("starve_stall", pipe_stall, c == 5);
      check_eq("starve_a3", rf_a3, (c == 5) ? 5'd5 : 5'd3);
      if (c == 5) check_eq("starve_wd", rf_wd, 32'h55);
      to_pos();
    end

    // Full queue holds off a third result; drain order is FIFO order
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_wd = 32'h3;
    set_mdu(5'd1, 32'hA);
    at_neg(); to_pos();
    set_mdu(5'd2, 32'hB);
    at_neg(); to_pos();
    set_mdu(5'd3, 32'hC);
    at_neg();
    check_eq("full_ready", mdu_ready, 1'b0);
    to_pos();
    mdu_valid = 1'b0;
    pipe_we   = 1'b0;
    at_neg();
    check_eq("ord1_a3", rf_a3, 5'd1);
    check_eq("ord1_wd", rf_wd, 32'hA);
    to_pos();
    at_neg();
    check_eq("ord2_a3", rf_a3, 5'd2);
    check_eq("ord2_wd", rf_wd, 32'hB);
    to_pos();
    at_neg();
    check_eq("ord_none", rf_we, 1'b0);
    to_pos();

    // r0 result is accepted but dropped
    idle_inputs();
    set_mdu(5'd0, 32'hFF);
    at_neg(); to_pos();
    idle_inputs();
    at_neg();
    check_eq("zero_we", rf_we, 1'b0);
    check_eq("zero_ready", mdu_ready, 1'b1);
    to_pos();

    // Scoreboard query against a queued entry
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_wd = 32'h3;
    set_mdu(5'd7, 32'h77);
    at_neg(); to_pos();
    mdu_valid = 1'b0;
    q_addr1 = 5'd7; q_addr2 = 5'd0;
    at_neg();
    check_eq("sb_hit1", q_hit, 1'b1);
    q_addr1 = 5'd0;
    #1 check_eq("sb_zero", q_hit, 1'b0);
    q_addr2 = 5'd7;
    #1 check_eq("sb_hit2", q_hit, 1'b1);
    to_pos();
    idle_inputs();
    at_neg(); to_pos();

    // Asynchronous reset while two entries are queued
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_wd = 32'h3;
    set_mdu(5'd11, 32'h1111);
    at_neg(); to_pos();
    set_mdu(5'd12, 32'h1212);
    at_neg(); to_pos();
    mdu_valid = 1'b0;
    q_addr1   = 5'd11;
    #1 rst = 1'b1;
    #1;
    check_eq("mrst_we", rf_we, 1'b0);
    check_eq("mrst_ready", mdu_ready, 1'b0);
    check_eq("mrst_qhit", q_hit, 1'b0);
    check_eq("mrst_stall", pipe_stall, 1'b0);
    #1 rst = 1'b0;
    model_reset();
    pipe_we = 1'b0;
    at_neg();
    check_eq("mrst_ready_after", mdu_ready, 1'b1);
    check_eq("mrst_no_stale", rf_we, 1'b0);
    to_pos();
    at_neg(); to_pos();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      pipe_we   = ($urandom_range(0, 9) < 6);
      pipe_addr = 5'($urandom_range(0, 7));
      pipe_wd   = $urandom;
      mdu_valid = ($urandom_range(0, 1) == 1);
      mdu_addr  = 5'($urandom_range(0, 7));
      mdu_wd    = $urandom;
      q_addr1   = 5'($urandom_range(0, 7));
      q_addr2   = 5'($urandom_range(0, 7));
      at_neg();
      to_pos();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Arbitrates the register file's single write port (we/A3/WD, written on the falling clock edge) between two sources:
- the main pipeline write-back stage;
- the multi-cycle multiply/divide unit (MDU).
MDU results are queued in a small FIFO. The pipeline has priority, and a wait counter bounds MDU starvation by stalling the pipeline for one cycle. A combinational scoreboard query tells decode whether a source register has a queued MDU write pending.

Parameters:
DEPTH, 2, MDU result FIFO depth; power of two, minimum 2
MAX_WAIT, 4, cycles a non-empty FIFO head may go unserved before a forced MDU grant; minimum 1

Ports:
clk  in  1  clock; one clock, all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
pipe_we  in  1  pipeline write-back request
pipe_addr  in  5  pipeline destination register
pipe_wd  in  32  pipeline write data
pipe_stall  out  1  pipeline write-back not accepted this cycle; hold request
mdu_valid  in  1  MDU result valid
mdu_addr  in  5  MDU destination register
mdu_wd  in  32  MDU result data
mdu_ready  out  1  FIFO can accept an MDU result
rf_we  out  1  register file write enable
rf_a3  out  5  register file write address
rf_wd  out  32  register file write data
q_addr1  in  5  decode source register 1
q_addr2  in  5  decode source register 2
q_hit  out  1  a queued MDU write targets q_addr1 or q_addr2

Behaviour:
- Reset (rst=1, asynchronous):
  - FIFO count, read pointer, write pointer and wait_cnt go to 0; state goes to IDLE; FIFO contents are discarded.
  - While rst=1: rf_we=0, mdu_ready=0, pipe_stall=0, q_hit=0.
  - Reset mid-drain loses all queued entries with no partial write.
- FSM states:
  - IDLE: FIFO empty.
  - DRAIN: FIFO non-empty, pipeline has priority.
  - FORCE: the MDU head is granted unconditionally.
- Transitions:
  - IDLE->DRAIN on push.
  - DRAIN->FORCE when the FIFO is non-empty, the head is not popped this cycle, and wait_cnt==MAX_WAIT-1.
  - FORCE lasts exactly one cycle, then goes to DRAIN if count after pop is >0, else IDLE.
  - DRAIN->IDLE when the last entry pops with no push.
- Grant (combinational, current cycle):
  - MDU granted iff FIFO non-empty and (pipe_we==0 or state==FORCE). Then rf_we=1, rf_a3/rf_wd=head, and the head pops at the rising edge.
  - Otherwise rf_we=pipe_we and (pipe_addr!=0); rf_a3=pipe_addr; rf_wd=pipe_wd.
  - pipe_stall = (state==FORCE) and pipe_we.
- wait_cnt:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on pop or when the FIFO is empty.
  - Saturates; never exceeds MAX_WAIT-1.
- FIFO:
  - mdu_ready = (count<DEPTH); there is no same-cycle pop credit.
  - Push on mdu_valid and mdu_ready. If mdu_addr==0, the result is accepted but not stored.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - No bypass: an entry pushed at edge N is grantable at the earliest in the cycle after edge N, giving a minimum 1-cycle acceptance-to-write latency.
  - Write order is FIFO order.
- Hazard contract:
  - The arbiter never reorders or cancels writes.
  - q_hit = OR over valid entries of (entry_addr==q_addr1 with q_addr1!=0) or (entry_addr==q_addr2 with q_addr2!=0). It covers FIFO entries only, not the incoming mdu_* inputs.
  - Decode must stall on q_hit, and the MDU owner must not issue a new MDU operation to a register with a pipeline write in flight.
- Widths: register address 5 bits, data 32 bits; count is clog2(DEPTH)+1 bits.

Decomposition:
- Shared package rf_arb_pkg holds:
  - REG_AW=5 and REG_DW=32;
  - state encoding constants ST_IDLE=0, ST_DRAIN=1, ST_FORCE=2 (2-bit).
- One sub-module, rf_wb_fifo:
  - DEPTH x (5+32) storage with push/pop, count, full and empty;
  - per-entry valid/address match against two query addresses, producing q_hit.
- The FSM, wait counter and grant mux stay in rf_wb_arbiter.

Test Plan:
- Pass-through: FIFO empty, pipe_we=1, pipe_addr=8, pipe_wd=0x1234 -> same cycle rf_we=1, rf_a3=8, rf_wd=0x1234, pipe_stall=0.
- Idle-slot drain: push MDU (addr 9, 0xDEAD) with pipe_we=0 -> next cycle rf_we=1, rf_a3=9, rf_wd=0xDEAD; FIFO empty after; state IDLE.
- Starvation: push MDU (addr 5, 0x55) with pipe_we held 1 continuously -> pipeline wins for 4 cycles; 5th cycle pipe_stall=1, rf_a3=5, rf_wd=0x55; pipe_stall=0 the following cycle.
- Full/ordering: push (1,0xA), (2,0xB) with pipe_we=1 -> mdu_ready=0 and a third mdu_valid is held off. Then drop pipe_we -> writes appear in the order r1=0xA, r2=0xB.
- Zero register and scoreboard:
  - push (0,0xFF) -> count stays 0 and no write occurs.
  - with (7,0x77) queued, q_addr1=7 -> q_hit=1; q_addr1=q_addr2=0 -> q_hit=0.
- Reset mid-operation: two entries queued, pulse rst asynchronously between edges -> rf_we=0 immediately; after release, count=0, no stale writes, mdu_ready=1.
